// File: rtl/axi_term_slv.sv
// Terminating AXI4+ATOP subordinate: accepts every burst and answers it locally with a fixed
// error response and a constant read data pattern, preserving IDs, lengths and per-queue order.
package axi_pkg;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned UserWidth = 1;
  localparam int unsigned ATOP_R_RESP = 5;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef logic [IdWidth-1:0]     id_t;
  typedef logic [AddrWidth-1:0]   addr_t;
  typedef logic [DataWidth-1:0]   data_t;
  typedef logic [DataWidth/8-1:0] strb_t;
  typedef logic [UserWidth-1:0]   user_t;

  typedef struct packed {
    id_t id; addr_t addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; logic lock;
    logic [3:0] cache; logic [2:0] prot; logic [3:0] qos; logic [3:0] region; logic [5:0] atop;
    user_t user;
  } aw_chan_t;
  typedef struct packed { data_t data; strb_t strb; logic last; user_t user; } w_chan_t;
  typedef struct packed { id_t id; logic [1:0] resp; user_t user; } b_chan_t;
  typedef struct packed {
    id_t id; addr_t addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; logic lock;
    logic [3:0] cache; logic [2:0] prot; logic [3:0] qos; logic [3:0] region; user_t user;
  } ar_chan_t;
  typedef struct packed { id_t id; data_t data; logic [1:0] resp; logic last; user_t user; } r_chan_t;

  typedef struct packed {
    aw_chan_t aw; logic aw_valid; w_chan_t w; logic w_valid; logic b_ready;
    ar_chan_t ar; logic ar_valid; logic r_ready;
  } axi_req_t;
  typedef struct packed {
    logic aw_ready; logic ar_ready; logic w_ready; logic b_valid; b_chan_t b;
    logic r_valid; r_chan_t r;
  } axi_resp_t;
endpackage

module axi_term_slv #(
  parameter int unsigned NumPending = 4,
  parameter logic [1:0]  Resp       = axi_pkg::RESP_DECERR,
  parameter logic [63:0] RespData   = 64'hBADC_AB1E_DEAD_BEEF,
  parameter type         req_t      = axi_pkg::axi_req_t,
  parameter type         resp_t     = axi_pkg::axi_resp_t
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  req_t  slv_req_i,
  output resp_t slv_resp_o,
  output logic  busy_o
);
  localparam int unsigned CntW = $clog2(NumPending + 1);
  localparam int unsigned PtrW = (NumPending > 1) ? $clog2(NumPending) : 1;
  typedef logic [CntW-1:0] cnt_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef enum logic {Idle, Send} r_state_e;

  axi_pkg::id_t aw_id_q [NumPending];
  ptr_t         aw_wr_q, aw_rd_q;
  cnt_t         aw_cnt_q;
  logic         w_done_q;

  axi_pkg::id_t ar_id_q  [NumPending];
  logic [7:0]   ar_len_q [NumPending];
  ptr_t         ar_wr_q, ar_rd_q;
  cnt_t         ar_cnt_q;
  r_state_e     r_state_q;
  logic [7:0]   beat_q;

  logic aw_full, aw_empty, ar_full, ar_empty, aw_atop_r;
  logic aw_ready, aw_push, aw_pop, atop_push, ar_ready, ar_push, ar_pop;
  logic w_ready, w_last_hs, b_valid, r_valid, r_last, r_hs;
  axi_pkg::id_t ar_push_id;
  logic [7:0]   ar_push_len;
  logic         unused_req;

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(NumPending - 1)) ? '0 : p + 1'b1;
  endfunction

  assign aw_full   = (aw_cnt_q == cnt_t'(NumPending));
  assign aw_empty  = (aw_cnt_q == '0);
  assign ar_full   = (ar_cnt_q == cnt_t'(NumPending));
  assign ar_empty  = (ar_cnt_q == '0);
  assign aw_atop_r = slv_req_i.aw.atop[axi_pkg::ATOP_R_RESP];

  // An AW carrying an R-response atomic also needs a slot in the read queue, and takes
  // precedence over a plain AR so only one entry is ever written per cycle.
  assign aw_ready    = !rst_i && !aw_full && !(aw_atop_r && ar_full);
  assign aw_push     = slv_req_i.aw_valid && aw_ready;
  assign atop_push   = aw_push && aw_atop_r;
  assign ar_ready    = !rst_i && !ar_full && !atop_push;
  assign ar_push     = (slv_req_i.ar_valid && ar_ready) || atop_push;
  assign ar_push_id  = atop_push ? slv_req_i.aw.id : slv_req_i.ar.id;
  assign ar_push_len = atop_push ? 8'd0 : slv_req_i.ar.len;

  assign w_ready   = !rst_i && !aw_empty && !w_done_q;
  assign w_last_hs = slv_req_i.w_valid && w_ready && slv_req_i.w.last;
  assign b_valid   = !rst_i && !aw_empty && w_done_q;
  assign aw_pop    = b_valid && slv_req_i.b_ready;

  assign r_valid = !rst_i && (r_state_q == Send);
  assign r_last  = (beat_q == ar_len_q[ar_rd_q]);
  assign r_hs    = r_valid && slv_req_i.r_ready;
  assign ar_pop  = r_hs && r_last;

  assign busy_o     = !aw_empty || !ar_empty;
  assign unused_req = ^slv_req_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_wr_q  <= '0;
      aw_rd_q  <= '0;
      aw_cnt_q <= '0;
      w_done_q <= 1'b0;
    end else begin
      if (aw_push) begin
        aw_id_q[aw_wr_q] <= slv_req_i.aw.id;
        aw_wr_q          <= next_ptr(aw_wr_q);
      end
      if (aw_pop) aw_rd_q <= next_ptr(aw_rd_q);
      aw_cnt_q <= aw_cnt_q + cnt_t'(aw_push) - cnt_t'(aw_pop);
      if (w_last_hs)   w_done_q <= 1'b1;
      else if (aw_pop) w_done_q <= 1'b0;
    end
  end

  // Send is entered on the push itself so the first beat appears the cycle after AR.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ar_wr_q   <= '0;
      ar_rd_q   <= '0;
      ar_cnt_q  <= '0;
      r_state_q <= Idle;
      beat_q    <= '0;
    end else begin
      if (ar_push) begin
        ar_id_q[ar_wr_q]  <= ar_push_id;
        ar_len_q[ar_wr_q] <= ar_push_len;
        ar_wr_q           <= next_ptr(ar_wr_q);
      end
      if (ar_pop) ar_rd_q <= next_ptr(ar_rd_q);
      ar_cnt_q <= ar_cnt_q + cnt_t'(ar_push) - cnt_t'(ar_pop);
      unique case (r_state_q)
        Idle: if (ar_push) r_state_q <= Send;
        Send: begin
          if (r_hs) begin
            if (r_last) begin
              beat_q <= '0;
              if (ar_cnt_q == cnt_t'(1) && !ar_push) r_state_q <= Idle;
            end else begin
              beat_q <= beat_q + 8'd1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = aw_ready;
    slv_resp_o.ar_ready = ar_ready;
    slv_resp_o.w_ready  = w_ready;
    slv_resp_o.b_valid  = b_valid;
    slv_resp_o.b.id     = aw_id_q[aw_rd_q];
    slv_resp_o.b.resp   = Resp;
    slv_resp_o.r_valid  = r_valid;
    slv_resp_o.r.id     = ar_id_q[ar_rd_q];
    slv_resp_o.r.data   = axi_pkg::data_t'(RespData);
    slv_resp_o.r.resp   = Resp;
    slv_resp_o.r.last   = r_last;
  end

  aw_no_overflow:  assert property (@(posedge clk_i) disable iff (rst_i) !(aw_push && aw_full));
  ar_no_overflow:  assert property (@(posedge clk_i) disable iff (rst_i) !(ar_push && ar_full));
  aw_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !(aw_pop && aw_empty));
  ar_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !(ar_pop && ar_empty));
  b_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (b_valid && !slv_req_i.b_ready) |=> (b_valid && $stable(slv_resp_o.b)));
  r_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_valid && !slv_req_i.r_ready) |=> (r_valid && $stable(slv_resp_o.r)));
endmodule

// File: tb/tb_axi_term_slv.sv
// Directed and randomised checks for the terminating AXI subordinate.
module tb_axi_term_slv;
  import axi_pkg::*;

  localparam logic [5:0]  ATOP_LOAD  = 6'b100000;
  localparam logic [5:0]  ATOP_STORE = 6'b010000;
  localparam logic [63:0] RESP_DATA  = 64'hBADC_AB1E_DEAD_BEEF;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  axi_req_t  req;
  axi_resp_t resp;
  logic      busy;
  int        vectors = 0;
  int        miscompares = 0;

  axi_term_slv #(.NumPending(4)) dut (
    .clk_i(clk), .rst_i(rst), .slv_req_i(req), .slv_resp_o(resp), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    req = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (resp.aw_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_aw_ready: got %0b want 0", resp.aw_ready); end
    vectors++; if (resp.ar_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ar_ready: got %0b want 0", resp.ar_ready); end
    vectors++; if (resp.w_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_w_ready: got %0b want 0", resp.w_ready); end
    vectors++; if (resp.b_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_b_valid: got %0b want 0", resp.b_valid); end
    vectors++; if (resp.r_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_r_valid: got %0b want 0", resp.r_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy: got %0b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (resp.aw_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rel_aw_ready: got %0b want 1", resp.aw_ready); end
    vectors++; if (resp.ar_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rel_ar_ready: got %0b want 1", resp.ar_ready); end
  endtask

  task automatic test_read_burst();
    @(negedge clk);
    req.ar_valid = 1'b1; req.ar.id = 4'd3; req.ar.len = 8'd3; req.r_ready = 1'b1;
    #1;
    vectors++; if (resp.ar_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rb_ar_ready: got %0b want 1", resp.ar_ready); end
    vectors++; if (resp.r_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rb_r_early: got %0b want 0", resp.r_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req.ar_valid = 1'b0;
      #1;
      vectors++; if (resp.r_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rb_r_valid beat %0d: got %0b want 1", i, resp.r_valid); end
      vectors++; if (resp.r.id !== 4'd3) begin miscompares++; $display("[TB] FAIL rb_r_id beat %0d: got %0d want 3", i, resp.r.id); end
      vectors++; if (resp.r.resp !== RESP_DECERR) begin miscompares++; $display("[TB] FAIL rb_r_resp beat %0d: got %0b want 11", i, resp.r.resp); end
      vectors++; if (resp.r.data !== RESP_DATA) begin miscompares++; $display("[TB] FAIL rb_r_data beat %0d: got %h want %h", i, resp.r.data, RESP_DATA); end
      vectors++; if (resp.r.last !== (i == 3)) begin miscompares++; $display("[TB] FAIL rb_r_last beat %0d: got %0b want %0b", i, resp.r.last, (i == 3)); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL rb_busy beat %0d: got %0b want 1", i, busy); end
    end
    @(negedge clk);
    #1;
    vectors++; if (resp.r_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rb_r_after: got %0b want 0", resp.r_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rb_busy_after: got %0b want 0", busy); end
    req.r_ready = 1'b0;
  endtask

  task automatic test_write_burst();
    @(negedge clk);
    req.aw_valid = 1'b1; req.aw.id = 4'd5; req.aw.len = 8'd1; req.aw.atop = '0; req.b_ready = 1'b1;
    #1;
    vectors++; if (resp.aw_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL wb_aw_ready: got %0b want 1", resp.aw_ready); end
    vectors++; if (resp.w_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL wb_w_before_aw: got %0b want 0", resp.w_ready); end
    @(negedge clk);
    req.aw_valid = 1'b0; req.w_valid = 1'b1; req.w.last = 1'b0; req.w.data = 64'h1111;
    #1;
    vectors++; if (resp.w_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL wb_w_ready0: got %0b want 1", resp.w_ready); end
    vectors++; if (resp.b_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL wb_b_early0: got %0b want 0", resp.b_valid); end
    @(negedge clk);
    req.w.last = 1'b1; req.w.data = 64'h2222;
    #1;
    vectors++; if (resp.w_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL wb_w_ready1: got %0b want 1", resp.w_ready); end
    vectors++; if (resp.b_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL wb_b_early1: got %0b want 0", resp.b_valid); end
    @(negedge clk);
    req.w_valid = 1'b0; req.w.last = 1'b0;
    #1;
    vectors++; if (resp.b_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL wb_b_valid: got %0b want 1", resp.b_valid); end
    vectors++; if (resp.b.id !== 4'd5) begin miscompares++; $display("[TB] FAIL wb_b_id: got %0d want 5", resp.b.id); end
    vectors++; if (resp.b.resp !== RESP_DECERR) begin miscompares++; $display("[TB] FAIL wb_b_resp: got %0b want 11", resp.b.resp); end
    vectors++; if (resp.w_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL wb_w_after_last: got %0b want 0", resp.w_ready); end
    @(negedge clk);
    #1;
    vectors++; if (resp.b_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL wb_b_single: got %0b want 0", resp.b_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL wb_busy_after: got %0b want 0", busy); end
    req.b_ready = 1'b0;
  endtask

  task automatic test_ar_full();
    logic [3:0] exp_id [4];
    logic [7:0] exp_len [4];
    logic [7:0] beat;
    int idx;
    exp_id  = '{4'd8, 4'd9, 4'd10, 4'd11};
    exp_len = '{8'd1, 8'd0, 8'd2, 8'd0};
    req.r_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req.ar_valid = 1'b1; req.ar.id = exp_id[k]; req.ar.len = exp_len[k];
      #1;
      vectors++; if (resp.ar_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL af_ar_ready%0d: got %0b want 1", k, resp.ar_ready); end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req.ar_valid = 1'b1; req.ar.id = 4'd12; req.ar.len = 8'd0;
      #1;
      vectors++; if (resp.ar_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL af_ar_full%0d: got %0b want 0", k, resp.ar_ready); end
    end
    idx = 0;
    beat = '0;
    for (int cyc = 0; cyc < 30 && idx < 4; cyc++) begin
      @(negedge clk);
      req.ar_valid = 1'b0; req.r_ready = 1'b1;
      #1;
      vectors++; if (resp.r_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL af_r_valid cyc %0d: got %0b want 1", cyc, resp.r_valid); end
      if (resp.r_valid) begin
        vectors++; if (resp.r.id !== exp_id[idx]) begin miscompares++; $display("[TB] FAIL af_r_id entry %0d: got %0d want %0d", idx, resp.r.id, exp_id[idx]); end
        vectors++; if (resp.r.last !== (beat == exp_len[idx])) begin miscompares++; $display("[TB] FAIL af_r_last entry %0d beat %0d: got %0b want %0b", idx, beat, resp.r.last, (beat == exp_len[idx])); end
        if (beat == exp_len[idx]) begin idx++; beat = '0; end
        else beat = beat + 8'd1;
      end
    end
    vectors++; if (idx != 4) begin miscompares++; $display("[TB] FAIL af_drain: got %0d entries want 4", idx); end
    @(negedge clk);
    req.r_ready = 1'b0;
    #1;
    vectors++; if (resp.r_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL af_r_after: got %0b want 0", resp.r_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL af_busy_after: got %0b want 0", busy); end
  endtask

  task automatic test_atop();
    @(negedge clk);
    req.aw_valid = 1'b1; req.aw.id = 4'd7; req.aw.len = 8'd0; req.aw.atop = ATOP_LOAD;
    req.ar_valid = 1'b1; req.ar.id = 4'd2; req.ar.len = 8'd0;
    req.r_ready = 1'b1; req.b_ready = 1'b1;
    #1;
    vectors++; if (resp.aw_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL at_aw_ready: got %0b want 1", resp.aw_ready); end
    vectors++; if (resp.ar_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL at_ar_blocked: got %0b want 0", resp.ar_ready); end
    @(negedge clk);
    req.aw_valid = 1'b0; req.aw.atop = '0;
    req.w_valid = 1'b1; req.w.last = 1'b1;
    #1;
    vectors++; if (resp.ar_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL at_ar_ready: got %0b want 1", resp.ar_ready); end
    vectors++; if (resp.r_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL at_r_valid0: got %0b want 1", resp.r_valid); end
    vectors++; if (resp.r.id !== 4'd7) begin miscompares++; $display("[TB] FAIL at_r_id0: got %0d want 7", resp.r.id); end
    vectors++; if (resp.r.last !== 1'b1) begin miscompares++; $display("[TB] FAIL at_r_last0: got %0b want 1", resp.r.last); end
    vectors++; if (resp.w_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL at_w_ready: got %0b want 1", resp.w_ready); end
    @(negedge clk);
    req.ar_valid = 1'b0; req.w_valid = 1'b0; req.w.last = 1'b0;
    #1;
    vectors++; if (resp.r_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL at_r_valid1: got %0b want 1", resp.r_valid); end
    vectors++; if (resp.r.id !== 4'd2) begin miscompares++; $display("[TB] FAIL at_r_id1: got %0d want 2", resp.r.id); end
    vectors++; if (resp.b_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL at_b_valid: got %0b want 1", resp.b_valid); end
    vectors++; if (resp.b.id !== 4'd7) begin miscompares++; $display("[TB] FAIL at_b_id: got %0d want 7", resp.b.id); end
    @(negedge clk);
    #1;
    vectors++; if (resp.r_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL at_r_after: got %0b want 0", resp.r_valid); end
    vectors++; if (resp.b_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL at_b_after: got %0b want 0", resp.b_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL at_busy_after: got %0b want 0", busy); end
    req.r_ready = 1'b0; req.b_ready = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    req.ar_valid = 1'b1; req.ar.id = 4'd9; req.ar.len = 8'd3; req.r_ready = 1'b1;
    #1;
    vectors++; if (resp.ar_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rm_ar_ready: got %0b want 1", resp.ar_ready); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req.ar_valid = 1'b0;
      #1;
      vectors++; if (resp.r_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rm_r_valid beat %0d: got %0b want 1", i, resp.r_valid); end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++; if (resp.r_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_r_in_reset: got %0b want 0", resp.r_valid); end
    @(negedge clk);
    rst = 1'b0; req.r_ready = 1'b0;
    #1;
    vectors++; if (resp.r_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_r_after_reset: got %0b want 0", resp.r_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_busy_after_reset: got %0b want 0", busy); end
    @(negedge clk);
    req.ar_valid = 1'b1; req.ar.id = 4'd4; req.ar.len = 8'd1; req.r_ready = 1'b1;
    #1;
    vectors++; if (resp.ar_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rm_ar2_ready: got %0b want 1", resp.ar_ready); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req.ar_valid = 1'b0;
      #1;
      vectors++; if (resp.r_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rm_r2_valid beat %0d: got %0b want 1", i, resp.r_valid); end
      vectors++; if (resp.r.id !== 4'd4) begin miscompares++; $display("[TB] FAIL rm_r2_id beat %0d: got %0d want 4", i, resp.r.id); end
      vectors++; if (resp.r.last !== (i == 1)) begin miscompares++; $display("[TB] FAIL rm_r2_last beat %0d: got %0b want %0b", i, resp.r.last, (i == 1)); end
    end
    @(negedge clk);
    #1;
    vectors++; if (resp.r_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_r2_after: got %0b want 0", resp.r_valid); end
    req.r_ready = 1'b0;
  endtask

  task automatic test_random_traffic();
    logic [3:0] exp_b [$];
    logic [7:0] wq [$];
    logic [3:0] exp_rid [$];
    logic [7:0] exp_rlen [$];
    int aw_left = 500, ar_left = 500, b_got = 0, rlast_got = 0, atop_loads = 0, cyc = 0;
    logic [7:0] wbeat = '0, rbeat = '0;
    logic w_done_m = 1'b0, aw_hs = 1'b0, ar_hs = 1'b0, w_hs = 1'b0, atop_hs, b_hs, r_hs;
    logic prev_b_stall = 1'b0, prev_r_stall = 1'b0;
    logic [3:0] prev_b_id = '0, prev_r_id = '0;
    logic exp_aw_ready, exp_ar_ready, exp_w_ready, exp_b_valid, exp_r_valid, exp_busy;
    bit done = 1'b0;
    req = '0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (aw_hs) req.aw_valid = 1'b0;
      if (ar_hs) req.ar_valid = 1'b0;
      if (w_hs)  req.w_valid  = 1'b0;
      if (!req.aw_valid && aw_left > 0 && $urandom_range(1, 0) == 1) begin
        req.aw_valid = 1'b1;
        req.aw.id    = 4'($urandom_range(15, 0));
        req.aw.len   = 8'($urandom_range(3, 0));
        case ($urandom_range(3, 0))
          0:       req.aw.atop = ATOP_LOAD;
          1:       req.aw.atop = ATOP_STORE;
          default: req.aw.atop = '0;
        endcase
      end
      if (!req.ar_valid && ar_left > 0 && $urandom_range(1, 0) == 1) begin
        req.ar_valid = 1'b1;
        req.ar.id    = 4'($urandom_range(15, 0));
        req.ar.len   = 8'($urandom_range(3, 0));
      end
      if (!req.w_valid && wq.size() > 0 && $urandom_range(3, 0) != 0) begin
        req.w_valid = 1'b1;
        req.w.last  = (wbeat == wq[0]);
        req.w.data  = {$urandom, $urandom};
      end
      req.b_ready = 1'($urandom_range(1, 0));
      req.r_ready = 1'($urandom_range(1, 0));
      #1;
      aw_hs   = req.aw_valid && resp.aw_ready;
      atop_hs = aw_hs && req.aw.atop[ATOP_R_RESP];
      ar_hs   = req.ar_valid && resp.ar_ready;
      w_hs    = req.w_valid && resp.w_ready;
      b_hs    = resp.b_valid && req.b_ready;
      r_hs    = resp.r_valid && req.r_ready;
      exp_aw_ready = (exp_b.size() < 4) && !(req.aw.atop[ATOP_R_RESP] && exp_rid.size() == 4);
      exp_ar_ready = (exp_rid.size() < 4) && !atop_hs;
      exp_w_ready  = (exp_b.size() > 0) && !w_done_m;
      exp_b_valid  = (exp_b.size() > 0) && w_done_m;
      exp_r_valid  = (exp_rid.size() > 0);
      exp_busy     = (exp_b.size() > 0) || (exp_rid.size() > 0);
      vectors++; if (resp.aw_ready !== exp_aw_ready) begin miscompares++; $display("[TB] FAIL rnd_aw_ready cyc %0d: got %0b want %0b", cyc, resp.aw_ready, exp_aw_ready); end
      vectors++; if (resp.ar_ready !== exp_ar_ready) begin miscompares++; $display("[TB] FAIL rnd_ar_ready cyc %0d: got %0b want %0b", cyc, resp.ar_ready, exp_ar_ready); end
      vectors++; if (resp.w_ready !== exp_w_ready) begin miscompares++; $display("[TB] FAIL rnd_w_ready cyc %0d: got %0b want %0b", cyc, resp.w_ready, exp_w_ready); end
      vectors++; if (resp.b_valid !== exp_b_valid) begin miscompares++; $display("[TB] FAIL rnd_b_valid cyc %0d: got %0b want %0b", cyc, resp.b_valid, exp_b_valid); end
      vectors++; if (resp.r_valid !== exp_r_valid) begin miscompares++; $display("[TB] FAIL rnd_r_valid cyc %0d: got %0b want %0b", cyc, resp.r_valid, exp_r_valid); end
      vectors++; if (busy !== exp_busy) begin miscompares++; $display("[TB] FAIL rnd_busy cyc %0d: got %0b want %0b", cyc, busy, exp_busy); end
      if (prev_b_stall) begin
        vectors++; if (resp.b_valid !== 1'b1 || resp.b.id !== prev_b_id) begin miscompares++; $display("[TB] FAIL rnd_b_stable cyc %0d: got v=%0b id=%0d want v=1 id=%0d", cyc, resp.b_valid, resp.b.id, prev_b_id); end
      end
      if (prev_r_stall) begin
        vectors++; if (resp.r_valid !== 1'b1 || resp.r.id !== prev_r_id) begin miscompares++; $display("[TB] FAIL rnd_r_stable cyc %0d: got v=%0b id=%0d want v=1 id=%0d", cyc, resp.r_valid, resp.r.id, prev_r_id); end
      end
      if (resp.b_valid && exp_b.size() > 0) begin
        vectors++; if (resp.b.id !== exp_b[0] || resp.b.resp !== RESP_DECERR) begin miscompares++; $display("[TB] FAIL rnd_b_payload cyc %0d: got id=%0d resp=%0b want id=%0d resp=11", cyc, resp.b.id, resp.b.resp, exp_b[0]); end
      end
      if (resp.r_valid && exp_rid.size() > 0) begin
        vectors++; if (resp.r.id !== exp_rid[0] || resp.r.last !== (rbeat == exp_rlen[0])) begin miscompares++; $display("[TB] FAIL rnd_r_payload cyc %0d: got id=%0d last=%0b want id=%0d last=%0b", cyc, resp.r.id, resp.r.last, exp_rid[0], (rbeat == exp_rlen[0])); end
        vectors++; if (resp.r.data !== RESP_DATA || resp.r.resp !== RESP_DECERR) begin miscompares++; $display("[TB] FAIL rnd_r_data cyc %0d: got %h/%0b want %h/11", cyc, resp.r.data, resp.r.resp, RESP_DATA); end
      end
      if (b_hs) begin
        if (exp_b.size() > 0) void'(exp_b.pop_front());
        w_done_m = 1'b0;
        b_got++;
      end
      if (aw_hs) begin
        exp_b.push_back(req.aw.id);
        wq.push_back(req.aw.len);
        aw_left--;
      end
      if (atop_hs) begin
        exp_rid.push_back(req.aw.id);
        exp_rlen.push_back(8'd0);
        atop_loads++;
      end
      if (ar_hs) begin
        exp_rid.push_back(req.ar.id);
        exp_rlen.push_back(req.ar.len);
        ar_left--;
      end
      if (w_hs && wq.size() > 0) begin
        if (req.w.last) begin
          void'(wq.pop_front());
          wbeat = '0;
          w_done_m = 1'b1;
        end else begin
          wbeat = wbeat + 8'd1;
        end
      end
      if (r_hs && exp_rid.size() > 0) begin
        if (rbeat == exp_rlen[0]) begin
          void'(exp_rid.pop_front());
          void'(exp_rlen.pop_front());
          rbeat = '0;
          rlast_got++;
        end else begin
          rbeat = rbeat + 8'd1;
        end
      end
      prev_b_stall = resp.b_valid && !req.b_ready;
      prev_b_id    = resp.b.id;
      prev_r_stall = resp.r_valid && !req.r_ready;
      prev_r_id    = resp.r.id;
      done = (aw_left == 0) && (ar_left == 0) && (exp_b.size() == 0) && (exp_rid.size() == 0) && (wq.size() == 0);
    end
    vectors++; if (!done) begin miscompares++; $display("[TB] FAIL rnd_timeout: got aw_left=%0d ar_left=%0d want all drained", aw_left, ar_left); end
    vectors++; if (b_got != 500) begin miscompares++; $display("[TB] FAIL rnd_b_count: got %0d want 500", b_got); end
    vectors++; if (rlast_got != 500 + atop_loads) begin miscompares++; $display("[TB] FAIL rnd_rlast_count: got %0d want %0d", rlast_got, 500 + atop_loads); end
    @(negedge clk);
    req = '0;
  endtask

  initial begin
    req = '0;
    test_reset();
    test_read_burst();
    test_write_burst();
    test_ar_full();
    test_atop();
    test_reset_mid_burst();
    test_random_traffic();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
